// File: rtl/lc5k_pkg.sv
// Shared types and helpers for the lc5k clock-enable divider bank.
package lc5k_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } lc5k_state_e;

    localparam int unsigned LC5K_MAX_NCH = 8;

    // Divisors of 0 and 1 both mean "pulse every cycle".
    function automatic logic [31:0] eff_div(input logic [31:0] div);
        return (div < 32'd2) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/lc5k_clkdiv_chan.sv
// One divider channel: free-running counter, divisor latch, registered CE pulse and toggle output.
module lc5k_clkdiv_chan
    import lc5k_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [DIV_W-1:0] div,
    input  logic             run,
    input  logic             start,
    input  logic             sync,
    output logic             ce,
    output logic             tgl
);

    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] div_lat_reg;
    logic             ce_reg;
    logic             tgl_reg;
    logic [31:0]      eff_w;
    logic             term;

    assign eff_w = eff_div(32'(div_lat_reg));
    assign term  = (32'(cnt_reg) == (eff_w - 32'd1));

    // The divisor is only resampled at a terminal count or a (re)start, so a
    // mid-period DIV change never shortens or stretches the running period.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg     <= '0;
            div_lat_reg <= '0;
            ce_reg      <= 1'b0;
            tgl_reg     <= 1'b0;
        end else if (!run) begin
            cnt_reg <= '0;
            ce_reg  <= 1'b0;
        end else if (sync) begin
            cnt_reg     <= '0;
            div_lat_reg <= div;
            ce_reg      <= 1'b0;
            tgl_reg     <= 1'b0;
        end else if (start) begin
            cnt_reg     <= '0;
            div_lat_reg <= div;
            ce_reg      <= 1'b0;
        end else if (term) begin
            cnt_reg     <= '0;
            div_lat_reg <= div;
            ce_reg      <= 1'b1;
            tgl_reg     <= ~tgl_reg;
        end else begin
            cnt_reg <= cnt_reg + DIV_W'(1);
            ce_reg  <= 1'b0;
        end
    end

    assign ce  = ce_reg;
    assign tgl = tgl_reg;

endmodule

// File: rtl/lc5k_clkdiv_bank.sv
// Multi-channel clock-enable divider gated by PLL lock settling.
// Optional macro LC5K_CLKDIV_SYNC_EN adds the SYNC phase-realignment input.
module lc5k_clkdiv_bank
    import lc5k_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int DIV_W    = 8,
    parameter int LOCK_CNT = 16,
    parameter int LOCK_W   = $clog2(LOCK_CNT + 1)
) (
    input  logic                 CLK,
    input  logic                 R,
    input  logic                 PLL_LOCK,
    input  logic [NCH*DIV_W-1:0] DIV,
    input  logic [NCH-1:0]       CH_EN,
    input  logic                 LOST_CLR,
`ifdef LC5K_CLKDIV_SYNC_EN
    input  logic                 SYNC,
`endif
    output logic [NCH-1:0]       CE,
    output logic [NCH-1:0]       TGL,
    output logic                 READY,
    output logic                 LOCK_LOST
);

    lc5k_state_e       state_reg, state_next;
    logic [LOCK_W-1:0] settle_cnt_reg, settle_cnt_next;
    logic              lock_lost_reg;
    logic [NCH-1:0]    en_prev_reg;
    logic              enter_run;
    logic              sync_req;
    logic [NCH-1:0]    chan_run;
    logic [NCH-1:0]    chan_start;
    logic [NCH-1:0]    chan_sync;

    always_ff @(posedge CLK) begin
        if (R) begin
            state_reg      <= WAIT_LOCK;
            settle_cnt_reg <= '0;
            lock_lost_reg  <= 1'b0;
            en_prev_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            settle_cnt_reg <= settle_cnt_next;
            en_prev_reg    <= CH_EN;
            // Loss of lock while running beats a simultaneous clear request.
            if (state_reg == RUN && !PLL_LOCK)
                lock_lost_reg <= 1'b1;
            else if (LOST_CLR)
                lock_lost_reg <= 1'b0;
        end
    end

    always_comb begin
        state_next      = state_reg;
        settle_cnt_next = settle_cnt_reg;
        case (state_reg)
            WAIT_LOCK: begin
                if (PLL_LOCK) begin
                    settle_cnt_next = LOCK_W'(1);
                    state_next      = (LOCK_CNT == 1) ? RUN : SETTLE;
                end
            end
            SETTLE: begin
                if (!PLL_LOCK) begin
                    settle_cnt_next = '0;
                    state_next      = WAIT_LOCK;
                end else begin
                    settle_cnt_next = settle_cnt_reg + LOCK_W'(1);
                    if (settle_cnt_next == LOCK_W'(LOCK_CNT))
                        state_next = RUN;
                end
            end
            RUN: begin
                if (!PLL_LOCK) begin
                    settle_cnt_next = '0;
                    state_next      = WAIT_LOCK;
                end
            end
            default: begin
                settle_cnt_next = '0;
                state_next      = WAIT_LOCK;
            end
        endcase
    end

    assign enter_run = (state_next == RUN) && (state_reg != RUN);

`ifdef LC5K_CLKDIV_SYNC_EN
    assign sync_req = SYNC && (state_reg == RUN);
`else
    assign sync_req = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            // A channel starts fresh on RUN entry or on its own enable rising edge.
            assign chan_run[gi]   = CH_EN[gi] && (state_next == RUN);
            assign chan_start[gi] = enter_run || !en_prev_reg[gi];
            assign chan_sync[gi]  = sync_req;

            lc5k_clkdiv_chan #(
                .DIV_W (DIV_W)
            ) u_chan (
                .clk   (CLK),
                .srst  (R),
                .div   (DIV[gi*DIV_W +: DIV_W]),
                .run   (chan_run[gi]),
                .start (chan_start[gi]),
                .sync  (chan_sync[gi]),
                .ce    (CE[gi]),
                .tgl   (TGL[gi])
            );
        end
    endgenerate

    assign READY     = (state_reg == RUN);
    assign LOCK_LOST = lock_lost_reg;

endmodule

// File: tb/tb_lc5k_clkdiv_bank.sv
// Self-checking bench for lc5k_clkdiv_bank (NCH=4, DIV_W=8, LOCK_CNT=16).
module tb_lc5k_clkdiv_bank;

    logic        clk = 1'b0;
    logic        r;
    logic        pll_lock;
    logic        lost_clr;
    logic [31:0] div;
    logic [3:0]  ch_en;
    logic        sync;
    logic [3:0]  ce;
    logic [3:0]  tgl;
    logic        ready;
    logic        lock_lost;

    always #5 clk = ~clk;

    lc5k_clkdiv_bank #(
        .NCH      (4),
        .DIV_W    (8),
        .LOCK_CNT (16)
    ) dut (
        .CLK       (clk),
        .R         (r),
        .PLL_LOCK  (pll_lock),
        .DIV       (div),
        .CH_EN     (ch_en),
        .LOST_CLR  (lost_clr),
`ifdef LC5K_CLKDIV_SYNC_EN
        .SYNC      (sync),
`endif
        .CE        (ce),
        .TGL       (tgl),
        .READY     (ready),
        .LOCK_LOST (lock_lost)
    );

    typedef struct {
        int         due;
        string      name;
        logic [3:0] ce;
        logic [3:0] ce_m;
        logic [3:0] tgl;
        logic [3:0] tgl_m;
        logic       ready;
        logic       lost;
    } exp_t;

    typedef struct {
        int    n;
        logic  r;
        logic  lock;
        logic  clr;
        logic  ready;
        logic  lost;
        string name;
    } vec_t;

    exp_t       sb[$];
    int         n_cmp   = 0;
    int         n_bad   = 0;
    int         cyc_cnt = 0;
    logic [3:0] exp_tgl = 4'h0;

    // Monitor: compares every expectation that falls due on this edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc_cnt++;
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc_cnt) begin
                exp_t e;
                e = sb.pop_front();
                n_cmp++;
                if (e.due != cyc_cnt ||
                    (ce & e.ce_m) !== (e.ce & e.ce_m) ||
                    (tgl & e.tgl_m) !== (e.tgl & e.tgl_m) ||
                    ready !== e.ready || lock_lost !== e.lost) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d: got ce=%b tgl=%b ready=%b lost=%b, want ce=%b(m%b) tgl=%b(m%b) ready=%b lost=%b",
                             e.name, cyc_cnt, ce, tgl, ready, lock_lost,
                             e.ce, e.ce_m, e.tgl, e.tgl_m, e.ready, e.lost);
                end else begin
                    $display("cyc=%0d %s ok ce=%b tgl=%b ready=%b lost=%b",
                             cyc_cnt, e.name, ce, tgl, ready, lock_lost);
                end
            end
        end
    end

    // Push the expectation for the coming edge, then advance past it.
    task automatic expect_next(input string name, input logic [3:0] e_ce, input logic [3:0] e_ce_m,
                               input logic [3:0] e_tgl, input logic [3:0] e_tgl_m,
                               input logic e_ready, input logic e_lost);
        exp_t e;
        e.due   = cyc_cnt + 1;
        e.name  = name;
        e.ce    = e_ce;
        e.ce_m  = e_ce_m;
        e.tgl   = e_tgl;
        e.tgl_m = e_tgl_m;
        e.ready = e_ready;
        e.lost  = e_lost;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Running-phase step: expected TGL follows from toggling on each expected CE.
    task automatic run_step(input string name, input logic [3:0] e_ce);
        exp_tgl = exp_tgl ^ e_ce;
        expect_next(name, e_ce, 4'hF, exp_tgl, 4'hF, 1'b1, 1'b0);
    endtask

    function automatic vec_t mkv(input int n, input logic vr, input logic vl, input logic vc,
                                 input logic vready, input logic vlost, input string vname);
        vec_t v;
        v.n = n; v.r = vr; v.lock = vl; v.clr = vc;
        v.ready = vready; v.lost = vlost; v.name = vname;
        return v;
    endfunction

    initial begin
        vec_t tbl[6];
        logic [3:0] c;

        tbl[0] = mkv(2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
        tbl[1] = mkv(8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
        tbl[2] = mkv(8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "settle8");
        tbl[3] = mkv(1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "settle_abort");
        tbl[4] = mkv(15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "resettle");
        tbl[5] = mkv(1,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "ready_rise");

        r        = 1'b1;
        pll_lock = 1'b0;
        lost_clr = 1'b0;
        sync     = 1'b0;
        ch_en    = 4'hF;
        div      = {8'd255, 8'd0, 8'd3, 8'd1};

        // Reset, settle abort and lock sequencing: no CE, TGL stays 0.
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                r        = tbl[i].r;
                pll_lock = tbl[i].lock;
                lost_clr = tbl[i].clr;
                expect_next(tbl[i].name, 4'h0, 4'hF, 4'h0, 4'hF, tbl[i].ready, tbl[i].lost);
            end
        end
        lost_clr = 1'b0;
        exp_tgl  = 4'h0;

        // Divide ratios 1, 3, 0, 255 over 600 cycles after RUN entry.
        for (int j = 1; j <= 600; j++) begin
            c = {(j % 255 == 0), 1'b1, (j % 3 == 0), 1'b1};
            run_step("div_ratio", c);
        end

        // ch1 DIV 3->4 right after a CE, then 4->2 two cycles after a later CE.
        div[15:8] = 8'd4;
        for (int j = 601; j <= 624; j++) begin
            if (j == 614) div[15:8] = 8'd2;
            c = {1'b0, 1'b1,
                 (j == 603) || (j >= 607 && j <= 615 && ((j - 607) % 4 == 0)) ||
                 (j > 615 && ((j - 615) % 2 == 0)),
                 1'b1};
            run_step("div_change", c);
        end

        // Lock loss with a same-cycle clear: the set wins, TGL is held.
        pll_lock = 1'b0;
        lost_clr = 1'b1;
        expect_next("lock_loss", 4'h0, 4'hF, exp_tgl, 4'hF, 1'b0, 1'b1);
        lost_clr = 1'b0;
        repeat (3) expect_next("lost_hold", 4'h0, 4'hF, exp_tgl, 4'hF, 1'b0, 1'b1);
        lost_clr = 1'b1;
        expect_next("lost_clr", 4'h0, 4'hF, exp_tgl, 4'hF, 1'b0, 1'b0);
        lost_clr = 1'b0;

        // Relock needs the full settle again.
        pll_lock = 1'b1;
        repeat (15) expect_next("relock_settle", 4'h0, 4'hF, exp_tgl, 4'hF, 1'b0, 1'b0);
        expect_next("relock_ready", 4'h0, 4'hF, exp_tgl, 4'hF, 1'b1, 1'b0);

        for (int j = 1; j <= 4; j++)
            run_step("relock_run", {1'b0, 1'b1, (j % 2 == 0), 1'b1});

        // ch1 disable then re-enable: first CE eff=2 cycles after the enable edge.
        ch_en = 4'b1101;
        repeat (2) run_step("ch1_off", 4'b0101);
        ch_en = 4'hF;
        for (int s = 0; s <= 5; s++)
            run_step("ch1_restart", {1'b0, 1'b1, (s > 0 && s % 2 == 0), 1'b1});

        // Reset mid-run while CE[0] is pulsing.
        r = 1'b1;
        expect_next("reset_mid", 4'h0, 4'hF, 4'h0, 4'hF, 1'b0, 1'b0);
        r = 1'b0;
        exp_tgl = 4'h0;
        repeat (15) expect_next("post_reset_settle", 4'h0, 4'hF, 4'h0, 4'hF, 1'b0, 1'b0);
        expect_next("post_reset_ready", 4'h0, 4'hF, 4'h0, 4'hF, 1'b1, 1'b0);
        for (int j = 1; j <= 3; j++)
            run_step("post_reset_run", {1'b0, 1'b1, (j % 2 == 0), 1'b1});

`ifdef LC5K_CLKDIV_SYNC_EN
        // SYNC zeroes TGL and CE, then every channel restarts its period.
        sync = 1'b1;
        exp_tgl = 4'h0;
        expect_next("sync", 4'h0, 4'hF, 4'h0, 4'hF, 1'b1, 1'b0);
        sync = 1'b0;
        for (int s = 1; s <= 4; s++)
            run_step("post_sync", {1'b0, 1'b1, (s % 2 == 0), 1'b1});
`endif

        @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
